vape_exec_sequencer: RTL and testbench
======================================

Name: vape_exec_sequencer

Overview:
- Sequences one Executable Region (ER) run per entry and tracks its lifecycle from legal entry at ER_min to legal exit from ER_max.
- Maintains the exec proof flag consumed by attestation.
- Arbitrates attestation snapshot requests against an in-flight ER run, so a report never samples exec mid-execution.
- Sits between the PC/violation monitors and the attestation front end.

Parameters:
- IRQ_ALLOWED, 0, 1 = interrupts during RUN are tolerated; 0 = an interrupt in RUN is a violation.
- CNT_W, 8, width of the completed-run counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- pc  in  16  current program counter.
- ER_min  in  16  first instruction address of ER.
- ER_max  in  16  last instruction address of ER.
- irq  in  1  interrupt taken this cycle.
- violation  in  1  OR/ER write or DMA violation from the monitors, level.
- attest_req  in  1  attestation snapshot request, level, held until ack.
- exec  out  1  proof-of-execution flag.
- busy  out  1  high while state == RUN.
- attest_ack  out  1  one-cycle pulse granting a snapshot.
- attest_exec  out  1  exec value captured with attest_ack.
- run_count  out  CNT_W  number of completed runs, saturating.

Behaviour:
- **Reset.** Synchronous: on the clk edge with reset_n=0, all registers clear.
  - state=IDLE; exec, busy, attest_ack, attest_exec = 0; run_count=0; prev_pc=0; pending=0.
- **Config check.** cfg_ok = (ER_min <= ER_max). While cfg_ok=0, RUN is never entered, and a RUN or DONE state moves to FAIL.
- **Region decode.**
  - in_er = (ER_min <= pc <= ER_max), unsigned 16-bit.
  - entry = (pc == ER_min).
  - prev_pc is registered every cycle.
- **States:** IDLE, RUN, DONE, FAIL.
- **IDLE** (exec=0): entry & !violation & cfg_ok -> RUN.
- **RUN** (exec=0, busy=1). Priority order, evaluated each cycle:
  1. violation, or irq & !IRQ_ALLOWED -> FAIL.
  2. !in_er & prev_pc == ER_max -> DONE (legal exit).
  3. !in_er otherwise -> FAIL (illegal exit).
  4. entry while in RUN (jump back to ER_min) -> remain in RUN.
- **DONE** (exec=1):
  - violation -> FAIL.
  - entry & !violation -> RUN (fresh run; exec drops to 0).
- **FAIL** (exec=0): entry & !violation & cfg_ok -> RUN.
- **Output timing.** exec and busy are registered and reflect the new state one cycle after the transition edge.
- **Simultaneous violation and legal exit** in the same cycle -> FAIL.
- **run_count** increments on each RUN->DONE transition and saturates at all-ones.
- **Attestation handshake.**
  - pending sets when attest_req=1 and no ack is outstanding.
  - Grant rule: when pending and the next state is not RUN, attest_ack=1 for exactly one cycle and attest_exec = the exec value registered that same cycle; pending clears.
  - While busy, the request is stalled and no ack is issued.
  - If RUN is entered in the same cycle a request arrives, RUN wins and the request remains pending.
  - attest_req must drop after ack. If it is still high one cycle after ack, that counts as a new request.
- **reset_n low mid-RUN or mid-handshake:** everything clears; no ack is emitted.

Test Plan:
- **Legal run.** ER_min=0xE000, ER_max=0xE010; pc 0x0100 -> 0xE000 … 0xE010 -> 0x0200, no violation.
  - Required: busy=1 during the run; exec=1 one cycle after pc=0x0200; run_count=1.
- **Illegal exit.** Same run, but pc jumps 0xE008 -> 0x0300.
  - Required: FAIL, exec=0, run_count unchanged.
- **Simultaneous events.** violation=1 in the same cycle as pc goes 0xE010 -> 0x0200.
  - Required: FAIL, exec=0.
- **Interrupt policy.** irq during RUN.
  - With IRQ_ALLOWED=0: FAIL.
  - With IRQ_ALLOWED=1: the run completes, exec=1.
- **Request stalled by RUN.** attest_req raised at cycle 3 of RUN, legal exit at cycle 10.
  - Required: no ack before DONE; one-cycle attest_ack with attest_exec=1 right after DONE.
  - Then violation in DONE -> exec=0; a new request acks with attest_exec=0.
- **Bad config, then reset.** ER_min=0xE020, ER_max=0xE010, pc=0xE020.
  - Required: no RUN, exec=0.
  - Then reset_n=0 for one cycle mid-RUN of a valid config: all outputs 0 and run_count=0 on the next edge.

Source files
------------

// File: rtl/vape_exec_sequencer.sv
// ---------------------------------------------------------------------------
// vape_exec_sequencer
//
// Tracks one Executable Region (ER) run at a time. A run begins at the first
// ER instruction and completes when the PC leaves the ER from its last
// instruction. The block keeps the exec proof flag for attestation. It also
// arbitrates attestation snapshot requests against an in-flight run, so exec
// is never sampled while the ER is executing.
//
// Parameters
//   IRQ_ALLOWED : 1 = interrupts are tolerated while in RUN,
//                 0 = an interrupt in RUN fails the run.
//   CNT_W       : width of the saturating completed-run counter.
//
// Ports
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   pc          in   current program counter
//   ER_min      in   first instruction address of the ER
//   ER_max      in   last instruction address of the ER
//   irq         in   interrupt taken this cycle
//   violation   in   write/DMA violation from the monitors (level)
//   attest_req  in   snapshot request (level, held until acknowledged)
//   exec        out  proof-of-execution flag
//   busy        out  high while the FSM is in RUN
//   attest_ack  out  one-cycle snapshot grant
//   attest_exec out  exec value captured with attest_ack
//   run_count   out  number of completed runs (saturating)
//   state_dbg   out  current FSM state (IDLE=0, RUN=1, DONE=2, FAIL=3)
//
// Handshake: attest_req is a level. It is latched as pending when no ack is
// outstanding. An ack is granted only in a cycle whose next state is not RUN.
// attest_ack is high for exactly one cycle. A request still high in the cycle
// after the ack counts as a new request.
// ---------------------------------------------------------------------------
module vape_exec_sequencer #(
    parameter int unsigned IRQ_ALLOWED = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      pc,
    input  logic [15:0]      ER_min,
    input  logic [15:0]      ER_max,
    input  logic             irq,
    input  logic             violation,
    input  logic             attest_req,
    output logic             exec,
    output logic             busy,
    output logic             attest_ack,
    output logic             attest_exec,
    output logic [CNT_W-1:0] run_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               exec_q, exec_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               ack_exec_q, ack_exec_d;
    logic               pending_q, pending_d;
    logic [15:0]        prev_pc_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic cfg_ok;
    logic in_er;
    logic entry;
    logic irq_bad;
    logic grant;

    assign cfg_ok  = (ER_min <= ER_max);
    assign in_er   = (pc >= ER_min) && (pc <= ER_max);
    assign entry   = (pc == ER_min);
    assign irq_bad = irq && (IRQ_ALLOWED == 0);

    // Next-state logic. RUN priority order: config, violation/irq,
    // legal exit, illegal exit, otherwise stay (this includes a jump back
    // to ER_min).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FAIL: begin
                if (entry && !violation && cfg_ok) state_d = RUN;
            end
            RUN: begin
                if (!cfg_ok)                             state_d = FAIL;
                else if (violation || irq_bad)           state_d = FAIL;
                else if (!in_er && prev_pc_q == ER_max)  state_d = DONE;
                else if (!in_er)                         state_d = FAIL;
                else                                     state_d = RUN;
            end
            DONE: begin
                if (!cfg_ok || violation)  state_d = FAIL;
                else if (entry)            state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and the handshake, all derived from the next state.
    always_comb begin
        exec_d     = (state_d == DONE);
        busy_d     = (state_d == RUN);
        grant      = pending_q && (state_d != RUN);
        ack_d      = grant;
        ack_exec_d = grant ? exec_d : 1'b0;
        // While an ack is being granted or is on the wire, attest_req is
        // still the old request, so it is not latched again.
        if (grant) pending_d = 1'b0;
        else       pending_d = pending_q || (attest_req && !ack_q);
        cnt_d = cnt_q;
        if (state_q == RUN && state_d == DONE && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            exec_q     <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            ack_exec_q <= 1'b0;
            pending_q  <= 1'b0;
            prev_pc_q  <= 16'h0000;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            exec_q     <= exec_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            ack_exec_q <= ack_exec_d;
            pending_q  <= pending_d;
            prev_pc_q  <= pc;
            cnt_q      <= cnt_d;
        end
    end

    assign exec        = exec_q;
    assign busy        = busy_q;
    assign attest_ack  = ack_q;
    assign attest_exec = ack_exec_q;
    assign run_count   = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_vape_exec_sequencer.sv
// Directed bench for vape_exec_sequencer. Two instances share all inputs.
// u_dut uses IRQ_ALLOWED=0 and CNT_W=8. u_dut_irq uses IRQ_ALLOWED=1 and
// CNT_W=2, so its counter saturates after three completed runs.
module tb_vape_exec_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] er_min = 16'hE000;
    logic [15:0] er_max = 16'hE010;
    logic        irq = 1'b0;
    logic        violation = 1'b0;
    logic        attest_req = 1'b0;

    logic       exec0, busy0, ack0, aexec0;
    logic [7:0] cnt0;
    logic [1:0] st0;
    logic       exec1, busy1, ack1, aexec1;
    logic [1:0] cnt1;
    logic [1:0] st1;

    int checks = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    vape_exec_sequencer #(.IRQ_ALLOWED(0), .CNT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .ER_min(er_min), .ER_max(er_max),
        .irq(irq), .violation(violation), .attest_req(attest_req),
        .exec(exec0), .busy(busy0), .attest_ack(ack0), .attest_exec(aexec0),
        .run_count(cnt0), .state_dbg(st0)
    );

    vape_exec_sequencer #(.IRQ_ALLOWED(1), .CNT_W(2)) u_dut_irq (
        .clk(clk), .reset_n(reset_n), .pc(pc), .ER_min(er_min), .ER_max(er_max),
        .irq(irq), .violation(violation), .attest_req(attest_req),
        .exec(exec1), .busy(busy1), .attest_ack(ack1), .attest_exec(aexec1),
        .run_count(cnt1), .state_dbg(st1)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Advance one cycle. Outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc_step(input logic [15:0] v);
        pc = v;
        step();
    endtask

    // Walk pc from a to b inclusive while in RUN, expecting busy and no ack.
    task automatic walk_er(input logic [15:0] a, input logic [15:0] b, input string tag);
        for (int p = int'(a); p <= int'(b); p++) begin
            set_pc_step(16'(p));
            check({tag, "_busy"}, {31'd0, busy0}, 32'd1);
            check({tag, "_noack"}, {31'd0, ack0}, 32'd0);
        end
    endtask

    initial begin
        // ---------- reset ----------
        reset_n = 1'b0;
        step();
        check("rst_state", {30'd0, st0}, {30'd0, S_IDLE});
        check("rst_exec", {31'd0, exec0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_ack", {31'd0, ack0}, 32'd0);
        check("rst_cnt", {24'd0, cnt0}, 32'd0);
        reset_n = 1'b1;

        // ---------- legal run ----------
        set_pc_step(16'h0100);
        check("idle_stay", {30'd0, st0}, {30'd0, S_IDLE});
        walk_er(16'hE000, 16'hE010, "legal");
        set_pc_step(16'h0200);
        check("legal_state", {30'd0, st0}, {30'd0, S_DONE});
        check("legal_exec", {31'd0, exec0}, 32'd1);
        check("legal_busy", {31'd0, busy0}, 32'd0);
        check("legal_cnt", {24'd0, cnt0}, 32'd1);
        set_pc_step(16'h0300);
        check("done_hold", {31'd0, exec0}, 32'd1);

        // ---------- illegal exit ----------
        walk_er(16'hE000, 16'hE008, "illeg");
        check("rerun_exec", {31'd0, exec0}, 32'd0);
        set_pc_step(16'h0300);
        check("illeg_state", {30'd0, st0}, {30'd0, S_FAIL});
        check("illeg_exec", {31'd0, exec0}, 32'd0);
        check("illeg_cnt", {24'd0, cnt0}, 32'd1);

        // ---------- violation together with legal exit ----------
        walk_er(16'hE000, 16'hE010, "simul");
        violation = 1'b1;
        set_pc_step(16'h0200);
        violation = 1'b0;
        check("simul_state", {30'd0, st0}, {30'd0, S_FAIL});
        check("simul_exec", {31'd0, exec0}, 32'd0);
        check("simul_cnt", {24'd0, cnt0}, 32'd1);

        // ---------- interrupt policy ----------
        set_pc_step(16'hE000);
        set_pc_step(16'hE001);
        irq = 1'b1;
        set_pc_step(16'hE002);
        irq = 1'b0;
        check("irq0_state", {30'd0, st0}, {30'd0, S_FAIL});
        check("irq1_state", {30'd0, st1}, {30'd0, S_RUN});
        for (int p = 16'hE003; p <= 16'hE010; p++) set_pc_step(16'(p));
        set_pc_step(16'h0200);
        check("irq0_exec", {31'd0, exec0}, 32'd0);
        check("irq1_exec", {31'd0, exec1}, 32'd1);
        check("irq1_cnt", {30'd0, cnt1}, 32'd2);
        check("irq0_cnt", {24'd0, cnt0}, 32'd1);

        // ---------- request stalled by RUN ----------
        walk_er(16'hE000, 16'hE002, "stall_a");
        attest_req = 1'b1;
        walk_er(16'hE003, 16'hE010, "stall_b");
        set_pc_step(16'h0200);
        check("stall_ack", {31'd0, ack0}, 32'd1);
        check("stall_aexec", {31'd0, aexec0}, 32'd1);
        check("stall_exec", {31'd0, exec0}, 32'd1);
        check("stall_cnt", {24'd0, cnt0}, 32'd2);
        // Still high for one cycle after the ack: not a new request yet.
        set_pc_step(16'h0300);
        check("ack_pulse", {31'd0, ack0}, 32'd0);
        attest_req = 1'b0;
        step();
        step();
        check("no_extra_ack", {31'd0, ack0}, 32'd0);

        // Violation in DONE, then request acks with exec=0.
        violation = 1'b1;
        step();
        violation = 1'b0;
        check("done_viol_state", {30'd0, st0}, {30'd0, S_FAIL});
        check("done_viol_exec", {31'd0, exec0}, 32'd0);
        attest_req = 1'b1;
        step();
        check("req2_wait", {31'd0, ack0}, 32'd0);
        step();
        check("req2_ack", {31'd0, ack0}, 32'd1);
        check("req2_aexec", {31'd0, aexec0}, 32'd0);
        attest_req = 1'b0;
        step();
        check("req2_pulse", {31'd0, ack0}, 32'd0);

        // ---------- RUN entry wins against a new request ----------
        attest_req = 1'b1;
        set_pc_step(16'hE000);
        attest_req = 1'b0;
        check("win_busy", {31'd0, busy0}, 32'd1);
        check("win_noack", {31'd0, ack0}, 32'd0);
        set_pc_step(16'hE010);
        check("win_noack2", {31'd0, ack0}, 32'd0);
        set_pc_step(16'h0200);
        check("win_ack", {31'd0, ack0}, 32'd1);
        check("win_aexec", {31'd0, aexec0}, 32'd1);
        check("win_cnt", {24'd0, cnt0}, 32'd3);
        check("sat_cnt", {30'd0, cnt1}, 32'd3);

        // ---------- bad config ----------
        er_min = 16'hE020;
        er_max = 16'hE010;
        set_pc_step(16'hE020);
        check("badcfg_state", {30'd0, st0}, {30'd0, S_FAIL});
        check("badcfg_exec", {31'd0, exec0}, 32'd0);
        step();
        check("badcfg_busy", {31'd0, busy0}, 32'd0);
        check("badcfg_norun", {30'd0, st0}, {30'd0, S_FAIL});

        // ---------- reset mid-RUN with a request in flight ----------
        er_min = 16'hE000;
        er_max = 16'hE010;
        set_pc_step(16'hE000);
        check("pre_rst_busy", {31'd0, busy0}, 32'd1);
        attest_req = 1'b1;
        set_pc_step(16'hE001);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        attest_req = 1'b0;
        check("mid_rst_state", {30'd0, st0}, {30'd0, S_IDLE});
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_exec", {31'd0, exec0}, 32'd0);
        check("mid_rst_ack", {31'd0, ack0}, 32'd0);
        check("mid_rst_cnt", {24'd0, cnt0}, 32'd0);
        check("mid_rst_cnt1", {30'd0, cnt1}, 32'd0);
        pc = 16'h0100;
        step();
        check("post_rst_ack", {31'd0, ack0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
